// File: rtl/fabric_cfg_pkg.sv
// Shared types and CRC constants for the configuration-chain loader.
// Holds the loader state encoding and the CRC-16 step function.
package fabric_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } load_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One MSB-first serial step of the CRC-16 register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16.sv
// Serial CRC-16 accumulator for bits returned from the chain tail.
// A clear request takes priority over an update in the same cycle.
module ccff_crc16
  import fabric_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        data_bit,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc16_step(crc, data_bit);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words MSB-first into the ccff configuration chain,
// tracks completion/timeout, and keeps fabric IOs isolated until a load completes.
module ccff_chain_loader
  import fabric_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32,
  parameter int TIMEOUT   = 4096
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              IO_ISOL_N,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       tail_crc
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int REM_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  load_state_t       state;
  load_state_t       state_next;
  logic [WORD_W-1:0] shreg;
  logic [REM_W-1:0]  rem_bits;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              io_isol_q;
  logic              load_start;
  logic              word_accept;
  logic              idle_cycle;
  logic              idle_expired;
  logic              chain_full;
  logic [31:0]       bits_left;
  logic [REM_W-1:0]  first_rem;

  // rem_bits counts bits still queued behind the one currently on ccff_head,
  // so a new word can be taken while the last bit of the previous one issues.
  assign load_start   = start && (state != LOAD);
  assign word_ready   = (state == LOAD) && (rem_bits == '0) && (bit_cnt < CNT_W'(CHAIN_LEN));
  assign word_accept  = word_ready && word_valid;
  assign idle_cycle   = word_ready && !word_valid;
  assign idle_expired = idle_cycle && (idle_cnt == IDLE_W'(TIMEOUT - 1));
  assign chain_full   = (bit_cnt == CNT_W'(CHAIN_LEN));
  assign bits_left    = 32'(CHAIN_LEN) - 32'(bit_cnt);
  assign first_rem    = (bits_left >= 32'(WORD_W)) ? REM_W'(WORD_W - 1) : REM_W'(bits_left - 32'd1);

  assign busy      = (state == LOAD);
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign IO_ISOL_N = io_isol_q;

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_next = LOAD;
      LOAD: begin
        if (idle_expired) begin
          state_next = ERROR;
        end else if (chain_full) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      shreg         <= '0;
      rem_bits      <= '0;
      bit_cnt       <= '0;
      idle_cnt      <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      io_isol_q     <= 1'b0;
    end else begin
      io_isol_q <= (state == DONE) && !start;
      if (load_start) begin
        shreg         <= '0;
        rem_bits      <= '0;
        bit_cnt       <= '0;
        idle_cnt      <= '0;
        ccff_head     <= 1'b0;
        ccff_shift_en <= 1'b0;
      end else if (state == LOAD && rem_bits != '0) begin
        ccff_head     <= shreg[WORD_W-1];
        shreg         <= shreg << 1;
        rem_bits      <= rem_bits - REM_W'(1);
        bit_cnt       <= bit_cnt + CNT_W'(1);
        ccff_shift_en <= 1'b1;
      end else if (word_accept) begin
        ccff_head     <= word_data[WORD_W-1];
        shreg         <= word_data << 1;
        rem_bits      <= first_rem;
        bit_cnt       <= bit_cnt + CNT_W'(1);
        idle_cnt      <= '0;
        ccff_shift_en <= 1'b1;
      end else begin
        ccff_head     <= 1'b0;
        ccff_shift_en <= 1'b0;
        if (idle_cycle) begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
      end
    end
  end

  ccff_crc16 u_crc (
    .clk      (prog_clk),
    .rst_n    (prog_rst_n),
    .clear    (load_start),
    .enable   (ccff_shift_en),
    .data_bit (ccff_tail),
    .crc      (tail_crc)
  );

endmodule
